// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction/data memory loader.
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_W          = 16;

  typedef enum logic [2:0] {
    CLEAR,
    HDR_HI,
    HDR_LO,
    WORD,
    DATA,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted stream bytes big-endian into 32-bit words; the word and its
// valid pulse are combinational so the caller can register them on the 4th byte.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [7:0]  data,
  output logic        word_valid,
  output logic [31:0] word
);

  // Only the three earlier bytes need storing; the fourth arrives with the push.
  logic [23:0] shift;
  logic [1:0]  cnt;

  assign word       = {shift, data};
  assign word_valid = push && (cnt == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift <= '0;
      cnt   <= '0;
    end else if (push) begin
      shift <= word[23:0];
      cnt   <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: clears instruction memory, loads a length-prefixed byte stream
// into it plus data word 0, then releases the CPU from reset.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter int ADDR_W     = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_data_o,
  output logic              dmem_we_o,
  output logic [31:0]       dmem_data_o,
  output logic              cpu_rst_o,
  output logic              start_o,
  output logic              error_o
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(IMEM_DEPTH - 1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] idx, idx_nx;
  logic [HDR_W-1:0]  count, count_nx;
  logic [HDR_W-1:0]  hdr_word;

  logic              accept;
  logic              push;
  logic              word_valid;
  logic [31:0]       word;

  logic              imem_we_nx;
  logic [ADDR_W-1:0] imem_addr_nx;
  logic [31:0]       imem_data_nx;
  logic              dmem_we_nx;
  logic [31:0]       dmem_data_nx;

  assign accept   = valid_i && ready_o;
  assign push     = accept && ((state == WORD) || (state == DATA));
  assign hdr_word = {count[HDR_W-1:8], data_i};

  byte_packer u_packer (
    .clk        (clk_i),
    .rst_n      (rst_i),
    .push       (push),
    .data       (data_i),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= CLEAR;
      idx   <= '0;
      count <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      count <= count_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    idx_nx       = idx;
    count_nx     = count;
    imem_we_nx   = 1'b0;
    imem_addr_nx = imem_addr_o;
    imem_data_nx = imem_data_o;
    dmem_we_nx   = 1'b0;
    dmem_data_nx = dmem_data_o;

    case (state)
      CLEAR: begin
        imem_we_nx   = 1'b1;
        imem_addr_nx = idx;
        imem_data_nx = '0;
        if (idx == LAST_IDX) begin
          idx_nx   = '0;
          state_nx = HDR_HI;
        end else begin
          idx_nx = idx + 1'b1;
        end
      end
      HDR_HI: begin
        if (accept) begin
          count_nx = {data_i, 8'h00};
          state_nx = HDR_LO;
        end
      end
      HDR_LO: begin
        if (accept) begin
          count_nx = hdr_word;
          idx_nx   = '0;
          if (32'(hdr_word) > 32'(IMEM_DEPTH))
            state_nx = ERR;
          else if (hdr_word == '0)
            state_nx = DATA;
          else
            state_nx = WORD;
        end
      end
      WORD: begin
        if (word_valid) begin
          imem_we_nx   = 1'b1;
          imem_addr_nx = idx;
          imem_data_nx = word;
          // Widen before incrementing so a full-depth load does not wrap.
          if ((32'(idx) + 32'd1) == 32'(count)) begin
            idx_nx   = '0;
            state_nx = DATA;
          end else begin
            idx_nx = idx + 1'b1;
          end
        end
      end
      DATA: begin
        if (word_valid) begin
          dmem_we_nx   = 1'b1;
          dmem_data_nx = word;
          state_nx     = DONE;
        end
      end
      default: begin
        state_nx = state;
      end
    endcase
  end

  // Status outputs follow the registered state, so they lag a transition by one edge.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ready_o     <= 1'b0;
      imem_we_o   <= 1'b0;
      imem_addr_o <= '0;
      imem_data_o <= '0;
      dmem_we_o   <= 1'b0;
      dmem_data_o <= '0;
      cpu_rst_o   <= 1'b0;
      start_o     <= 1'b0;
      error_o     <= 1'b0;
    end else begin
      ready_o     <= (state == HDR_HI) || (state == HDR_LO) ||
                     (state == WORD)   || (state == DATA);
      imem_we_o   <= imem_we_nx;
      imem_addr_o <= imem_addr_nx;
      imem_data_o <= imem_data_nx;
      dmem_we_o   <= dmem_we_nx;
      dmem_data_o <= dmem_data_nx;
      cpu_rst_o   <= (state == DONE);
      start_o     <= (state == DONE);
      error_o     <= (state == ERR);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: stream-position model of expected writes.
module tb_imem_loader;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic [7:0]  data_i = 8'h00;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic        imem_we_o;
  logic [7:0]  imem_addr_o;
  logic [31:0] imem_data_o;
  logic        dmem_we_o;
  logic [31:0] dmem_data_o;
  logic        cpu_rst_o;
  logic        start_o;
  logic        error_o;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] strm[$];

  imem_loader #(.IMEM_DEPTH(DEPTH), .ADDR_W(8)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .imem_we_o   (imem_we_o),
    .imem_addr_o (imem_addr_o),
    .imem_data_o (imem_data_o),
    .dmem_we_o   (dmem_we_o),
    .dmem_data_o (dmem_data_o),
    .cpu_rst_o   (cpu_rst_o),
    .start_o     (start_o),
    .error_o     (error_o)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_i   = 1'b0;
    valid_i = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({ready_o, imem_we_o, dmem_we_o, cpu_rst_o, start_o, error_o} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got rdy=%b iwe=%b dwe=%b crst=%b start=%b err=%b want all 0",
               ready_o, imem_we_o, dmem_we_o, cpu_rst_o, start_o, error_o);
    end
    vectors++;
    if ({imem_addr_o, imem_data_o, dmem_data_o} !== 72'h0) begin
      miscompares++;
      $display("FAIL reset_data: got addr=%h idata=%h ddata=%h want 0",
               imem_addr_o, imem_data_o, dmem_data_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_clear();
    rst_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (imem_we_o !== 1'b1 || imem_addr_o !== 8'(i) || imem_data_o !== 32'h0) begin
        miscompares++;
        $display("FAIL clear_write %0d: got we=%b addr=%h data=%h want 1 %h 0",
                 i, imem_we_o, imem_addr_o, imem_data_o, 8'(i));
      end
      vectors++;
      if (ready_o !== 1'b0 || start_o !== 1'b0 || cpu_rst_o !== 1'b0) begin
        miscompares++;
        $display("FAIL clear_ctrl %0d: got rdy=%b start=%b crst=%b want 0 0 0",
                 i, ready_o, start_o, cpu_rst_o);
      end
    end
    @(posedge clk); #1;
    vectors++;
    if (ready_o !== 1'b1 || imem_we_o !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_end: got rdy=%b we=%b want 1 0", ready_o, imem_we_o);
    end
  endtask

  task automatic build_random(input int n);
    strm.delete();
    strm.push_back(8'(n >> 8));
    strm.push_back(8'(n));
    for (int i = 0; i < 4 * n + 4; i++) strm.push_back(8'($urandom));
  endtask

  // mode 0: continuous valid, 1: valid every other cycle, 2: random gaps.
  task automatic run_load(input int n, input int mode, input int limit);
    int pos = 0;
    int cyc = 0;
    int k;
    bit acc;
    bit exp_we;
    bit exp_dwe;
    logic [31:0] ew;
    while (pos < limit && cyc < 6000) begin
      if (mode == 0) valid_i = 1'b1;
      else if (mode == 1) valid_i = (cyc % 2 == 0);
      else valid_i = 1'($urandom_range(0, 1));
      data_i = valid_i ? strm[pos] : 8'($urandom);
      acc = valid_i && ready_o;
      k = pos;
      @(posedge clk); #1;
      cyc++;
      if (acc) pos++;
      exp_we  = acc && n <= DEPTH && k >= 2 && k < 2 + 4 * n && ((k - 2) % 4 == 3);
      exp_dwe = acc && n <= DEPTH && k == 2 + 4 * n + 3;
      vectors++;
      if (imem_we_o !== exp_we) begin
        miscompares++;
        $display("FAIL imem_we byte %0d: got %b want %b", k, imem_we_o, exp_we);
      end
      if (exp_we) begin
        ew = {strm[k-3], strm[k-2], strm[k-1], strm[k]};
        vectors++;
        if (imem_addr_o !== 8'((k - 2) / 4) || imem_data_o !== ew) begin
          miscompares++;
          $display("FAIL imem_word %0d: got addr=%h data=%h want %h %h",
                   (k - 2) / 4, imem_addr_o, imem_data_o, 8'((k - 2) / 4), ew);
        end
      end
      vectors++;
      if (dmem_we_o !== exp_dwe) begin
        miscompares++;
        $display("FAIL dmem_we byte %0d: got %b want %b", k, dmem_we_o, exp_dwe);
      end
      if (exp_dwe) begin
        ew = {strm[k-3], strm[k-2], strm[k-1], strm[k]};
        vectors++;
        if (dmem_data_o !== ew) begin
          miscompares++;
          $display("FAIL dmem_data: got %h want %h", dmem_data_o, ew);
        end
      end
      vectors++;
      if (ready_o !== 1'b1 || start_o !== 1'b0 || cpu_rst_o !== 1'b0 || error_o !== 1'b0) begin
        miscompares++;
        $display("FAIL load_ctrl byte %0d: got rdy=%b start=%b crst=%b err=%b want 1 0 0 0",
                 k, ready_o, start_o, cpu_rst_o, error_o);
      end
    end
    valid_i = 1'b0;
    if (pos < limit) begin
      vectors++;
      miscompares++;
      $display("FAIL load_timeout: got %0d bytes want %0d", pos, limit);
    end
  endtask

  task automatic test_after(input bit want_err);
    bit want_go = !want_err;
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if (start_o !== want_go || cpu_rst_o !== want_go || error_o !== want_err || ready_o !== 1'b0) begin
        miscompares++;
        $display("FAIL final_ctrl %0d: got start=%b crst=%b err=%b rdy=%b want %b %b %b 0",
                 i, start_o, cpu_rst_o, error_o, ready_o, want_go, want_go, want_err);
      end
      vectors++;
      if (imem_we_o !== 1'b0 || dmem_we_o !== 1'b0) begin
        miscompares++;
        $display("FAIL final_nowrite %0d: got iwe=%b dwe=%b want 0 0", i, imem_we_o, dmem_we_o);
      end
      valid_i = 1'b1;
      data_i  = 8'($urandom);
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
  endtask

  task automatic test_fixed(input int mode);
    strm = '{8'h00, 8'h02, 8'h8C, 8'h01, 8'h00, 8'h00, 8'h00, 8'h22, 8'h18, 8'h20,
             8'h00, 8'h00, 8'h00, 8'h05};
    test_reset();
    test_clear();
    run_load(2, mode, strm.size());
    test_after(1'b0);
  endtask

  task automatic test_random(input int n, input int mode);
    build_random(n);
    test_reset();
    test_clear();
    run_load(n, mode, strm.size());
    test_after(1'b0);
  endtask

  task automatic test_empty();
    strm = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05};
    test_reset();
    test_clear();
    run_load(0, 2, strm.size());
    test_after(1'b0);
  endtask

  task automatic test_error();
    strm = '{8'h01, 8'h01};
    test_reset();
    test_clear();
    run_load(257, 0, 2);
    test_after(1'b1);
  endtask

  task automatic test_midload_reset();
    build_random(2);
    test_reset();
    test_clear();
    run_load(2, 0, 8);
    test_reset();
    test_clear();
    build_random(3);
    run_load(3, 2, strm.size());
    test_after(1'b0);
  endtask

  initial begin
    test_fixed(0);
    test_fixed(1);
    test_random($urandom_range(1, 6), 2);
    test_empty();
    test_error();
    test_random(DEPTH, 0);
    test_midload_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
